// File: rtl/mem_access_unit_if.sv
// Request, data-memory and response signals of the MEM-stage load/store unit.
// The master modport is the unit's view; slave is the pipeline/memory side.
interface mem_access_unit_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned NB = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte enables, lane-replicated store data, a
// req/ack memory transaction with timeout, and extended load responses.
module mem_access_unit #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_unit_if.master bus
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_FULL} sz_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    err_n;
  logic          accept;
  logic [2:0]    op_q;
  logic [LB-1:0] lane_q;

  // Word ops collapse to full width when the bus is only one word wide.
  function automatic sz_t size_of(input logic [2:0] op);
    unique case (op)
      3'b001, 3'b010: return SZ_BYTE;
      3'b011, 3'b100: return SZ_HALF;
      3'b101, 3'b110: return (DW == 64) ? SZ_WORD : SZ_FULL;
      default:        return SZ_FULL;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  endfunction

  sz_t           req_sz;
  logic [LB-1:0] req_lane;
  logic          req_misalign;
  logic [NB-1:0] req_be;
  logic [DW-1:0] req_wrep;

  // Request decode: alignment, byte enables and replicated store data.
  always_comb begin
    req_lane     = bus.req_addr[LB-1:0];
    req_sz       = size_of(bus.req_op);
    req_misalign = 1'b0;
    req_be       = '1;
    req_wrep     = bus.req_wdata;
    unique case (req_sz)
      SZ_BYTE: begin
        req_be   = NB'(1) << req_lane;
        req_wrep = {NB{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_misalign = req_lane[0];
        req_be       = NB'(3) << req_lane;
        req_wrep     = {(NB/2){bus.req_wdata[15:0]}};
      end
      SZ_WORD: begin
        req_misalign = (req_lane[1:0] != 2'b00);
        req_be       = NB'(4'hF) << req_lane;
        req_wrep     = {(NB/4){bus.req_wdata[31:0]}};
      end
      default: req_misalign = (req_lane != '0);
    endcase
  end

  logic [DW-1:0] rd_shift, load_ext;

  always_comb begin
    rd_shift = bus.mem_rdata >> {lane_q, 3'b000};
    load_ext = rd_shift;
    unique case (size_of(op_q))
      SZ_BYTE: load_ext = is_signed(op_q) ? DW'($signed(rd_shift[7:0]))  : DW'(rd_shift[7:0]);
      SZ_HALF: load_ext = is_signed(op_q) ? DW'($signed(rd_shift[15:0])) : DW'(rd_shift[15:0]);
      SZ_WORD: load_ext = is_signed(op_q) ? DW'($signed(rd_shift[31:0])) : DW'(rd_shift[31:0]);
      default: load_ext = rd_shift;
    endcase
  end

  // Next-state logic; the counter times how long mem_req has been held.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = ERR_OK;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == 3'b111) begin
            state_n = RESP;
            err_n   = ERR_ILLEGAL;
          end else if (req_misalign) begin
            state_n = RESP;
            err_n   = ERR_MISALIGN;
          end else begin
            state_n = ACCESS;
            cnt_n   = '0;
            accept  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_n = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = RESP;
          err_n   = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      bus.req_ready <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= ERR_OK;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.req_ready <= (state_n == IDLE);
      bus.mem_req   <= (state_n == ACCESS);
      bus.rsp_valid <= (state_n == RESP);
      bus.rsp_err   <= (state_n == RESP) ? err_n : ERR_OK;
      // Load data is captured only on the acknowledging edge of a load.
      bus.rsp_rdata <= (state == ACCESS && bus.mem_ack && !bus.mem_we) ? load_ext : '0;
      if (accept) begin
        op_q          <= bus.req_op;
        lane_q        <= req_lane;
        bus.mem_we    <= bus.req_we;
        bus.mem_addr  <= bus.req_addr & ~AW'(NB - 1);
        bus.mem_be    <= req_be;
        bus.mem_wdata <= req_wrep;
      end else if (state_n != ACCESS) begin
        bus.mem_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences (timeout, reset
// mid-access) and random requests against a byte-level reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel64 = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(32), .DW(32)) b32();
  mem_access_unit_if #(.AW(32), .DW(64)) b64();

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32.master));
  mem_access_unit #(.AW(32), .DW(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64.master));

  typedef struct {
    bit        w64;
    bit        we;
    bit [2:0]  op;
    bit [31:0] addr;
    bit [63:0] wdata;
    bit [63:0] rdata;
    int        dly;
    bit [1:0]  err;
    bit [31:0] eaddr;
    bit [7:0]  ebe;
    bit [63:0] ewdata;
    bit [63:0] erdata;
  } vec_t;

  typedef struct {
    logic        req_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;
  } obs_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit w64, we, input bit [2:0] op, input bit [31:0] addr,
                              input bit [63:0] wdata, rdata, input int dly, input bit [1:0] err,
                              input bit [31:0] eaddr, input bit [7:0] ebe,
                              input bit [63:0] ewdata, erdata);
    vec_t v;
    v.w64 = w64; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.dly = dly; v.err = err; v.eaddr = eaddr; v.ebe = ebe; v.ewdata = ewdata; v.erdata = erdata;
    return v;
  endfunction

  // Reference: access size in bytes, natural alignment, byte-array gather/scatter.
  function automatic vec_t model(input bit w64, we, input bit [2:0] op, input bit [31:0] addr,
                                 input bit [63:0] wdata, rdata, input int dly);
    vec_t v;
    int nb, sz, lane;
    bit sgn;
    nb   = w64 ? 8 : 4;
    sz   = (op == 1 || op == 2) ? 1 : (op == 3 || op == 4) ? 2 : (op == 5 || op == 6) ? 4 : nb;
    sgn  = (op == 2 || op == 4 || op == 6) && (sz < nb);
    lane = int'(addr[2:0]) % nb;
    v = mk(w64, we, op, addr, wdata, rdata, dly, 2'b00, addr - 32'(lane), 8'h00, 64'h0, 64'h0);
    v.err = (op == 7) ? 2'b11 : ((lane % sz) != 0) ? 2'b01 : 2'b00;
    if (v.err == 2'b00) begin
      for (int i = 0; i < nb; i++) begin
        if (i >= lane && i < lane + sz) v.ebe[i] = 1'b1;
        v.ewdata[i*8 +: 8] = wdata[(i % sz)*8 +: 8];
      end
      if (!we) begin
        for (int i = 0; i < nb; i++) begin
          if (i < sz) v.erdata[i*8 +: 8] = rdata[(lane + i)*8 +: 8];
          else if (sgn && rdata[(lane + sz)*8 - 1]) v.erdata[i*8 +: 8] = 8'hFF;
        end
      end
    end
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    if (sel64) begin
      o.req_ready = b64.req_ready; o.mem_req = b64.mem_req; o.mem_we = b64.mem_we;
      o.mem_addr = b64.mem_addr; o.mem_be = b64.mem_be; o.mem_wdata = b64.mem_wdata;
      o.rsp_valid = b64.rsp_valid; o.rsp_rdata = b64.rsp_rdata; o.rsp_err = b64.rsp_err;
    end else begin
      o.req_ready = b32.req_ready; o.mem_req = b32.mem_req; o.mem_we = b32.mem_we;
      o.mem_addr = b32.mem_addr; o.mem_be = 8'(b32.mem_be); o.mem_wdata = 64'(b32.mem_wdata);
      o.rsp_valid = b32.rsp_valid; o.rsp_rdata = 64'(b32.rsp_rdata); o.rsp_err = b32.rsp_err;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input bit v, input vec_t t);
    b32.req_valid = v & ~t.w64;  b64.req_valid = v & t.w64;
    b32.req_we    = t.we;        b64.req_we    = t.we;
    b32.req_op    = t.op;        b64.req_op    = t.op;
    b32.req_addr  = t.addr;      b64.req_addr  = t.addr;
    b32.req_wdata = t.wdata[31:0];
    b64.req_wdata = t.wdata;
  endtask

  task automatic drive_idle();
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
  endtask

  task automatic set_ack(input bit a, input bit [63:0] d);
    b32.mem_ack = a & ~sel64;  b64.mem_ack = a & sel64;
    b32.mem_rdata = d[31:0];   b64.mem_rdata = d;
  endtask

  task automatic check_reset(input string tag);
    obs_t o;
    o = sample();
    check({tag, ".ready"},  64'(o.req_ready), 64'd1);
    check({tag, ".mreq"},   64'(o.mem_req),   64'd0);
    check({tag, ".mwe"},    64'(o.mem_we),    64'd0);
    check({tag, ".maddr"},  64'(o.mem_addr),  64'd0);
    check({tag, ".mbe"},    64'(o.mem_be),    64'd0);
    check({tag, ".mwdata"}, o.mem_wdata,      64'd0);
    check({tag, ".rvalid"}, 64'(o.rsp_valid), 64'd0);
    check({tag, ".rdata"},  o.rsp_rdata,      64'd0);
    check({tag, ".rerr"},   64'(o.rsp_err),   64'd0);
  endtask

  // One request issued at the current negedge, followed to the idle cycle after RESP.
  task automatic run_txn(input vec_t v, input string tag);
    obs_t o;
    sel64 = v.w64;
    o = sample();
    check({tag, ".ready"}, 64'(o.req_ready), 64'd1);
    drive_req(1'b1, v);
    @(negedge clk);
    drive_idle();
    o = sample();
    if (v.err != 2'b00) begin
      check({tag, ".mreq"},   64'(o.mem_req),   64'd0);
      check({tag, ".rvalid"}, 64'(o.rsp_valid), 64'd1);
      check({tag, ".rerr"},   64'(o.rsp_err),   64'(v.err));
      check({tag, ".rdata"},  o.rsp_rdata,      64'd0);
    end else begin
      check({tag, ".mreq"},   64'(o.mem_req),  64'd1);
      check({tag, ".maddr"},  64'(o.mem_addr), 64'(v.eaddr));
      check({tag, ".mbe"},    64'(o.mem_be),   64'(v.ebe));
      check({tag, ".mwe"},    64'(o.mem_we),   64'(v.we));
      check({tag, ".mwdata"}, o.mem_wdata,     v.ewdata);
      for (int k = 0; k < v.dly; k++) begin
        @(negedge clk);
        o = sample();
        check({tag, ".hold"}, 64'(o.mem_req), 64'd1);
      end
      set_ack(1'b1, v.rdata);
      @(negedge clk);
      set_ack(1'b0, 64'h0);
      o = sample();
      check({tag, ".rvalid"}, 64'(o.rsp_valid), 64'd1);
      check({tag, ".rerr"},   64'(o.rsp_err),   64'd0);
      check({tag, ".rdata"},  o.rsp_rdata,      v.erdata);
      check({tag, ".mreq_off"}, 64'(o.mem_req), 64'd0);
    end
    @(negedge clk);
    o = sample();
    check({tag, ".pulse"},  64'(o.rsp_valid), 64'd0);
    check({tag, ".ready2"}, 64'(o.req_ready), 64'd1);
  endtask

  initial begin
    vec_t t;
    obs_t o;
    int hi, rsp_at;
    drive_req(1'b0, mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_ack(1'b0, 64'h0);

    #12;
    sel64 = 1'b0; check_reset("rst32");
    sel64 = 1'b1; check_reset("rst64");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    tbl.push_back(mk(0, 0, 3'b010, 32'h1003, 0, 64'h80FF1234, 2, 2'b00, 32'h1000, 8'h08, 0, 64'hFFFFFF80));
    tbl.push_back(mk(0, 0, 3'b011, 32'h2002, 0, 64'h80017FFF, 0, 2'b00, 32'h2000, 8'h0C, 0, 64'h00008001));
    tbl.push_back(mk(0, 0, 3'b100, 32'h2002, 0, 64'h80017FFF, 1, 2'b00, 32'h2000, 8'h0C, 0, 64'hFFFF8001));
    tbl.push_back(mk(0, 1, 3'b001, 32'h0011, 64'hA5, 64'hDEADBEEF, 1, 2'b00, 32'h0010, 8'h02, 64'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 0, 3'b100, 32'h3001, 0, 0, 0, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b111, 32'h4000, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b101, 32'h0106, 0, 0, 0, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'b110, 32'h0204, 0, 64'h80000000_00000000, 1, 2'b00, 32'h0200, 8'hF0, 0, 64'hFFFFFFFF_80000000));
    tbl.push_back(mk(0, 0, 3'b110, 32'h0020, 0, 64'h80000000, 0, 2'b00, 32'h0020, 8'h0F, 0, 64'h80000000));
    tbl.push_back(mk(0, 0, 3'b101, 32'h0022, 0, 0, 0, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b000, 32'h0008, 64'h11223344_55667788, 0, 0, 2'b00, 32'h0008, 8'hFF, 64'h11223344_55667788, 0));
    tbl.push_back(mk(1, 1, 3'b011, 32'h0036, 64'hBEEF, 0, 2, 2'b00, 32'h0030, 8'hC0, 64'hBEEFBEEF_BEEFBEEF, 0));
    tbl.push_back(mk(1, 0, 3'b001, 32'h0045, 0, 64'h00112233_44556677, 0, 2'b00, 32'h0040, 8'h20, 0, 64'h22));
    tbl.push_back(mk(0, 0, 3'b011, 32'h0001, 0, 0, 0, 2'b01, 0, 0, 0, 0));
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Timeout on the TIMEOUT=4 instance, then a stray ack that must be ignored.
    sel64 = 1'b0;
    t = mk(0, 0, 3'b001, 32'h0500, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(1'b1, t);
    @(negedge clk);
    drive_idle();
    hi = 0;
    rsp_at = -1;
    for (int k = 0; k < 10; k++) begin
      o = sample();
      if (o.mem_req) hi++;
      if (o.rsp_valid) begin
        rsp_at = k;
        break;
      end
      @(negedge clk);
    end
    check("tmo.req_cycles", 64'(hi), 64'd4);
    check("tmo.rsp_cycle", 64'(rsp_at), 64'd4);
    check("tmo.rerr", 64'(o.rsp_err), 64'd2);
    check("tmo.rdata", o.rsp_rdata, 64'd0);
    set_ack(1'b1, 64'hFFFFFFFF);
    @(negedge clk);
    set_ack(1'b0, 64'h0);
    o = sample();
    check("tmo.stray_rvalid", 64'(o.rsp_valid), 64'd0);
    check("tmo.stray_mreq", 64'(o.mem_req), 64'd0);
    run_txn(mk(0, 0, 3'b001, 32'h0502, 0, 64'h00AB0000, 1, 2'b00, 32'h0500, 8'h04, 0, 64'hAB), "tmo.next");

    // Reset in the second ACCESS cycle drops mem_req at once.
    t = mk(0, 0, 3'b000, 32'h0600, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(1'b1, t);
    @(negedge clk);
    drive_idle();
    o = sample();
    check("rstmid.mreq_on", 64'(o.mem_req), 64'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 o = sample();
    check("rstmid.mreq_off", 64'(o.mem_req), 64'd0);
    check("rstmid.rvalid", 64'(o.rsp_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    o = sample();
    check("rstmid.ready", 64'(o.req_ready), 64'd1);
    run_txn(mk(0, 0, 3'b000, 32'h0600, 0, 64'hCAFEF00D, 0, 2'b00, 32'h0600, 8'h0F, 0, 64'hCAFEF00D), "rstmid.next");

    for (int n = 0; n < 200; n++) begin
      bit w;
      bit [63:0] wd, rd;
      w  = 1'($urandom_range(0, 1));
      wd = {32'($urandom), 32'($urandom)};
      rd = {32'($urandom), 32'($urandom)};
      if (!w) begin
        wd[63:32] = '0;
        rd[63:32] = '0;
      end
      t = model(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
                wd, rd, $urandom_range(0, 2));
      run_txn(t, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
